instr_fetch: RTL and testbench

//  Instruction fetch stage, directly upstream of the program memory.
//  - Owns the program counter and drives the program-memory read address.
//  - Captures the combinational read data into an instruction register.
//  - Hands each instruction to decode over a valid/ready handshake.
//  - Supports jumps from decode, stalls via backpressure, and a halt state.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/ifetch_pc.sv | 44 ++++
 rtl/instr_fetch.sv | 163 ++++++++++++++++
 tb/tb_instr_fetch.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage. Program memory and
// decode use the same default widths.
//   DATA_SIZE     : default instruction / program-memory data width
//   ADDR_SIZE     : default PC / program-memory address width
//   fetch_state_t : fetch controller states
// ----------------------------------------------------------------------------
package fetch_pkg;

  localparam int DATA_SIZE = 6;
  localparam int ADDR_SIZE = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/ifetch_pc.sv
// ----------------------------------------------------------------------------
// ifetch_pc
// Program counter for the fetch stage. It contains the PC register, the
// incrementer, the jump mux and the last-address detect.
// Ports:
//   clk        in  clock
//   rst        in  synchronous active-high reset (PC -> 0)
//   inc_i      in  advance PC by one (modulo 2**ADDR_SIZE)
//   jmp_i      in  load jmp_addr_i into PC (takes priority over inc_i)
//   jmp_addr_i in  jump target
//   pc_o       out current PC
//   last_o     out PC is at the highest address
// ----------------------------------------------------------------------------
module ifetch_pc
  import fetch_pkg::*;
#(
  parameter int ADDR_SIZE = fetch_pkg::ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_i,
  input  logic                 jmp_i,
  input  logic [ADDR_SIZE-1:0] jmp_addr_i,
  output logic [ADDR_SIZE-1:0] pc_o,
  output logic                 last_o
);

  logic [ADDR_SIZE-1:0] pc_q;

  // The increment overflows naturally, which gives the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else if (jmp_i) begin
      pc_q <= jmp_addr_i;
    end else if (inc_i) begin
      pc_q <= pc_q + ADDR_SIZE'(1);
    end
  end

  assign pc_o   = pc_q;
  assign last_o = &pc_q;

endmodule

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
// This is the instruction fetch stage, placed directly upstream of program
// memory. It drives the read address from the PC and registers the read data
// into an instruction register. Decode receives each instruction over a
// valid/ready handshake.
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   en_i           start fetching (only looked at in IDLE)
//   halt_i         stop fetching and park in HALT until reset
//   pc_o           program-memory read address
//   mem_data_i     program-memory read data (combinational on pc_o)
//   instr_o        instruction register
//   instr_pc_o     address instr_o was fetched from
//   instr_valid_o  instr_o holds an unconsumed instruction
//   instr_ready_i  decode accepts instr_o this cycle
//   jmp_valid_i    redirect the PC to jmp_addr_i
//   jmp_addr_i     jump target
//   halted_o       high while in HALT
// Build option:
//   IFETCH_HALT_WRAP_EN  when this macro is defined, fetching stops at the top
//                        address. The last instruction is drained and the
//                        stage then halts. Without the macro, the PC wraps
//                        to 0 and fetching continues.
// ----------------------------------------------------------------------------
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int DATA_SIZE = fetch_pkg::DATA_SIZE,
  parameter int ADDR_SIZE = fetch_pkg::ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 halt_i,
  output logic [ADDR_SIZE-1:0] pc_o,
  input  logic [DATA_SIZE-1:0] mem_data_i,
  output logic [DATA_SIZE-1:0] instr_o,
  output logic [ADDR_SIZE-1:0] instr_pc_o,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  input  logic                 jmp_valid_i,
  input  logic [ADDR_SIZE-1:0] jmp_addr_i,
  output logic                 halted_o
);

`ifdef IFETCH_HALT_WRAP_EN
  localparam bit HALT_ON_WRAP = 1'b1;
`else
  localparam bit HALT_ON_WRAP = 1'b0;
`endif

  fetch_state_t state_q, state_d;

  logic                 load;
  logic                 load_en;
  logic                 pc_inc;
  logic                 pc_jmp;
  logic                 valid_clr;
  logic                 pc_last;
  logic [ADDR_SIZE-1:0] pc;

  ifetch_pc #(
    .ADDR_SIZE (ADDR_SIZE)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (pc_inc),
    .jmp_i      (pc_jmp),
    .jmp_addr_i (jmp_addr_i),
    .pc_o       (pc),
    .last_o     (pc_last)
  );

  // The instruction register can take new data when it is empty or when its
  // current contents are being consumed this cycle.
  assign load = !instr_valid_o || instr_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and datapath controls. In RUN and DRAIN, halt has
  // priority over jump, and jump has priority over load. A jump only clears
  // valid, so an instruction accepted in the same cycle is not lost.
  always_comb begin
    state_d   = state_q;
    load_en   = 1'b0;
    pc_inc    = 1'b0;
    pc_jmp    = 1'b0;
    valid_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          load_en = 1'b1;
          pc_inc  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (halt_i) begin
          valid_clr = 1'b1;
          state_d   = HALT;
        end else if (jmp_valid_i) begin
          pc_jmp    = 1'b1;
          valid_clr = 1'b1;
        end else if (load) begin
          load_en = 1'b1;
          // With halt-on-wrap, the PC parks on the top address. The last
          // word is handed off from DRAIN.
          if (HALT_ON_WRAP && pc_last) begin
            state_d = DRAIN;
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (halt_i) begin
          valid_clr = 1'b1;
          state_d   = HALT;
        end else if (jmp_valid_i) begin
          pc_jmp    = 1'b1;
          valid_clr = 1'b1;
          state_d   = RUN;
        end else if (instr_valid_o && instr_ready_i) begin
          valid_clr = 1'b1;
          state_d   = HALT;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // This is the instruction register. On a load, it records the word and the
  // address it came from, which gives one cycle of latency from pc_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_o       <= '0;
      instr_pc_o    <= '0;
      instr_valid_o <= 1'b0;
    end else if (load_en) begin
      instr_o       <= mem_data_i;
      instr_pc_o    <= pc;
      instr_valid_o <= 1'b1;
    end else if (valid_clr) begin
      instr_valid_o <= 1'b0;
    end
  end

  assign pc_o     = pc;
  assign halted_o = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
// This is the testbench for instr_fetch. A local array models program memory
// and drives mem_data_i combinationally from pc_o. First, a table of
// directed vectors exercises start, backpressure, jump, halt, reset and wrap.
// Then randomized inputs are compared against a behavioural reference model.
// Build option: IFETCH_HALT_WRAP_EN selects the halt-on-wrap expectations.
// ----------------------------------------------------------------------------
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam int DW    = DATA_SIZE;
  localparam int AW    = ADDR_SIZE;
  localparam int DEPTH = 1 << AW;

`ifdef IFETCH_HALT_WRAP_EN
  localparam bit WRAP_HALT = 1'b1;
`else
  localparam bit WRAP_HALT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          en_i;
  logic          halt_i;
  logic [AW-1:0] pc_o;
  logic [DW-1:0] mem_data_i;
  logic [DW-1:0] instr_o;
  logic [AW-1:0] instr_pc_o;
  logic          instr_valid_o;
  logic          instr_ready_i;
  logic          jmp_valid_i;
  logic [AW-1:0] jmp_addr_i;
  logic          halted_o;

  logic [DW-1:0] mem [DEPTH];

  int tests  = 0;
  int errors = 0;
  int xfers  = 0;

  assign mem_data_i = mem[pc_o];

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .en_i          (en_i),
    .halt_i        (halt_i),
    .pc_o          (pc_o),
    .mem_data_i    (mem_data_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .jmp_valid_i   (jmp_valid_i),
    .jmp_addr_i    (jmp_addr_i),
    .halted_o      (halted_o)
  );

  typedef struct {
    logic          rst;
    logic          en;
    logic          halt;
    logic          ready;
    logic          jmp;
    logic [AW-1:0] jaddr;
    logic [DW-1:0] e_instr;
    logic [AW-1:0] e_ipc;
    logic          e_valid;
    logic [AW-1:0] e_pc;
    logic          e_halted;
  } vec_t;

  vec_t vecs[$];

  // Reference model state. The mode values are 0 idle, 1 fetching,
  // 2 draining, and 3 halted.
  int            m_mode;
  int            m_pc;
  int            m_ipc;
  logic [DW-1:0] m_instr;
  bit            m_valid;

  task automatic addVec(input logic r, e, h, rd, j, input logic [AW-1:0] ja,
                        input logic [DW-1:0] ei, input logic [AW-1:0] eipc,
                        input logic ev, input logic [AW-1:0] epc, input logic eh);
    vec_t v;
    v.rst = r; v.en = e; v.halt = h; v.ready = rd; v.jmp = j; v.jaddr = ja;
    v.e_instr = ei; v.e_ipc = eipc; v.e_valid = ev; v.e_pc = epc; v.e_halted = eh;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, count handshakes, and advance past the edge.
  task automatic applyStimulus(input logic r, e, h, rd, j, input logic [AW-1:0] ja);
    rst           = r;
    en_i          = e;
    halt_i        = h;
    instr_ready_i = rd;
    jmp_valid_i   = j;
    jmp_addr_i    = ja;
    if (!r && instr_valid_o && rd) xfers++;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] ei,
                             input logic [AW-1:0] eipc, input logic ev,
                             input logic [AW-1:0] epc, input logic eh);
    tests++;
    if (instr_o !== ei || instr_pc_o !== eipc || instr_valid_o !== ev ||
        pc_o !== epc || halted_o !== eh) begin
      errors++;
      $display("[TB] FAIL %s: got instr=%h ipc=%h valid=%b pc=%h halted=%b, expected instr=%h ipc=%h valid=%b pc=%h halted=%b",
               tag, instr_o, instr_pc_o, instr_valid_o, pc_o, halted_o,
               ei, eipc, ev, epc, eh);
    end
  endtask

  task automatic modelTake();
    m_instr = mem[m_pc];
    m_ipc   = m_pc;
    m_valid = 1'b1;
    if (WRAP_HALT && m_pc == DEPTH - 1) m_mode = 2;
    else m_pc = (m_pc + 1) % DEPTH;
  endtask

  task automatic modelStep(input logic r, e, h, rd, j, input logic [AW-1:0] ja);
    if (r) begin
      m_mode = 0; m_pc = 0; m_ipc = 0; m_instr = '0; m_valid = 1'b0;
    end else if (m_mode == 0) begin
      if (e) begin
        m_mode = 1;
        modelTake();
      end
    end else if (m_mode == 1 || m_mode == 2) begin
      if (h) begin
        m_valid = 1'b0;
        m_mode  = 3;
      end else if (j) begin
        m_pc    = int'(ja);
        m_valid = 1'b0;
        m_mode  = 1;
      end else if (m_mode == 1 && (!m_valid || rd)) begin
        modelTake();
      end else if (m_mode == 2 && m_valid && rd) begin
        m_valid = 1'b0;
        m_mode  = 3;
      end
    end
  endtask

  initial begin
    logic [AW-1:0] wrap_pc;
    rst = 1'b1; en_i = 1'b0; halt_i = 1'b0; instr_ready_i = 1'b0;
    jmp_valid_i = 1'b0; jmp_addr_i = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 1);
    repeat (2) @(posedge clk);
    #1;

    wrap_pc = WRAP_HALT ? AW'(31) : AW'(0);

    //      rst en  hlt rdy jmp addr      instr   ipc     v    pc      halted
    addVec(1, 0, 0, 1, 0, 5'h00, 6'h00, 5'd0,  0, 5'd0,  0);  // reset
    addVec(0, 1, 0, 1, 0, 5'h00, 6'h01, 5'd0,  1, 5'd1,  0);  // start
    addVec(0, 0, 0, 1, 0, 5'h00, 6'h02, 5'd1,  1, 5'd2,  0);
    addVec(0, 0, 0, 1, 0, 5'h00, 6'h03, 5'd2,  1, 5'd3,  0);
    addVec(0, 0, 0, 0, 0, 5'h00, 6'h03, 5'd2,  1, 5'd3,  0);  // stall x3
    addVec(0, 0, 0, 0, 0, 5'h00, 6'h03, 5'd2,  1, 5'd3,  0);
    addVec(0, 0, 0, 0, 0, 5'h00, 6'h03, 5'd2,  1, 5'd3,  0);
    addVec(0, 0, 0, 1, 0, 5'h00, 6'h04, 5'd3,  1, 5'd4,  0);
    addVec(0, 0, 0, 1, 1, 5'h10, 6'h04, 5'd3,  0, 5'd16, 0);  // jump + xfer
    addVec(0, 0, 0, 1, 0, 5'h00, 6'h11, 5'd16, 1, 5'd17, 0);
    addVec(0, 0, 1, 1, 1, 5'h05, 6'h11, 5'd16, 0, 5'd17, 1);  // halt > jmp
    addVec(0, 1, 0, 1, 1, 5'h05, 6'h11, 5'd16, 0, 5'd17, 1);  // halt sticky
    addVec(1, 0, 0, 1, 0, 5'h00, 6'h00, 5'd0,  0, 5'd0,  0);
    addVec(0, 1, 0, 0, 0, 5'h00, 6'h01, 5'd0,  1, 5'd1,  0);
    addVec(0, 0, 0, 0, 0, 5'h00, 6'h01, 5'd0,  1, 5'd1,  0);
    addVec(1, 0, 0, 0, 0, 5'h00, 6'h00, 5'd0,  0, 5'd0,  0);  // reset mid-run
    addVec(0, 0, 1, 1, 1, 5'h07, 6'h00, 5'd0,  0, 5'd0,  0);  // idle ignores
    addVec(0, 1, 0, 1, 0, 5'h00, 6'h01, 5'd0,  1, 5'd1,  0);
    addVec(0, 0, 0, 1, 1, 5'd29, 6'h01, 5'd0,  0, 5'd29, 0);
    addVec(0, 0, 0, 1, 0, 5'h00, 6'h1e, 5'd29, 1, 5'd30, 0);
    addVec(0, 0, 0, 1, 0, 5'h00, 6'h1f, 5'd30, 1, 5'd31, 0);
    addVec(0, 0, 0, 1, 0, 5'h00, 6'h20, 5'd31, 1, wrap_pc, 0);
    if (WRAP_HALT) begin
      addVec(0, 0, 0, 1, 0, 5'h00, 6'h20, 5'd31, 0, 5'd31, 1);
      addVec(0, 1, 0, 1, 1, 5'h03, 6'h20, 5'd31, 0, 5'd31, 1);
    end else begin
      addVec(0, 0, 0, 1, 0, 5'h00, 6'h01, 5'd0,  1, 5'd1,  0);
      addVec(0, 1, 0, 1, 1, 5'h03, 6'h01, 5'd0,  0, 5'd3,  0);
    end
    addVec(1, 0, 0, 1, 0, 5'h00, 6'h00, 5'd0,  0, 5'd0,  0);
    addVec(0, 1, 0, 1, 0, 5'h00, 6'h01, 5'd0,  1, 5'd1,  0);
    addVec(0, 0, 0, 1, 1, 5'd30, 6'h01, 5'd0,  0, 5'd30, 0);
    addVec(0, 0, 0, 1, 0, 5'h00, 6'h1f, 5'd30, 1, 5'd31, 0);
    addVec(0, 0, 0, 1, 0, 5'h00, 6'h20, 5'd31, 1, wrap_pc, 0);
    addVec(0, 0, 0, 0, 0, 5'h00, 6'h20, 5'd31, 1, wrap_pc, 0);
    addVec(0, 0, 0, 0, 1, 5'd2,  6'h20, 5'd31, 0, 5'd2,  0);  // jump from drain
    addVec(0, 0, 0, 1, 0, 5'h00, 6'h03, 5'd2,  1, 5'd3,  0);

    xfers = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].halt, vecs[i].ready,
                    vecs[i].jmp, vecs[i].jaddr);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_ipc,
                  vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_halted);
      if (i == 9) begin
        tests++;
        if (xfers != 4) begin
          errors++;
          $display("[TB] FAIL xfer_count: got %0d, expected 4", xfers);
        end
      end
    end

    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    for (int c = 0; c < 3000; c++) begin
      logic          r, e, h, rd, j;
      logic [AW-1:0] ja;
      r  = (c == 0) || ($urandom_range(0, 59) == 0);
      e  = ($urandom_range(0, 1) == 0);
      h  = ($urandom_range(0, 39) == 0);
      rd = ($urandom_range(0, 3) != 0);
      j  = ($urandom_range(0, 7) == 0);
      ja = AW'($urandom);
      modelStep(r, e, h, rd, j, ja);
      applyStimulus(r, e, h, rd, j, ja);
      checkOutput($sformatf("rand%0d", c), m_instr, AW'(m_ipc), m_valid,
                  AW'(m_pc), m_mode == 3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
